ps2_key_decoder: RTL

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver that decodes make/break scan codes into held-button levels for up to four players.
// Define PS2_PARITY_CHECK_EN to reject frames with even parity; otherwise the parity bit is ignored.
module ps2_key_decoder #(
  parameter int unsigned                  NUM_PLAYERS    = 2,
  parameter logic [NUM_PLAYERS*45-1:0]    KEYMAP         = {9'h05A, 9'h04B, 9'h03B, 9'h042, 9'h043,
                                                            9'h029, 9'h023, 9'h01C, 9'h01B, 9'h01D},
  parameter int unsigned                  TIMEOUT_CYCLES = 50000
) (
  input  logic                     clk_50m,
  input  logic                     rst_n,
  input  logic                     kclk,
  input  logic                     kdata,
  output logic [NUM_PLAYERS*5-1:0] btns,
  output logic [7:0]               scan_code,
  output logic                     scan_valid,
  output logic                     frame_err
);

  localparam int unsigned NB = NUM_PLAYERS * 5;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t          state, state_n;
  logic [3:0]      bit_cnt, bit_cnt_n;
  logic [TW-1:0]   to_cnt, to_cnt_n;
  logic            kclk_s1, kclk_s2, kclk_d;
  logic            kdata_s1, kdata_s2;
  logic            fall;
  logic            frame_done, timeout;
  logic            parity_ok, frame_ok;
  logic [8:0]      rx_sr;
  logic [7:0]      rx_byte;
  logic            ext, brk;
  logic [NB-1:0]   btns_n;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      kclk_s1  <= 1'b1;
      kclk_s2  <= 1'b1;
      kclk_d   <= 1'b1;
      kdata_s1 <= 1'b1;
      kdata_s2 <= 1'b1;
    end else begin
      kclk_s1  <= kclk;
      kclk_s2  <= kclk_s1;
      kclk_d   <= kclk_s2;
      kdata_s1 <= kdata;
      kdata_s2 <= kdata_s1;
    end
  end

  assign fall = kclk_d & ~kclk_s2;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      to_cnt  <= to_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    to_cnt_n   = to_cnt;
    frame_done = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        to_cnt_n = '0;
        if (fall && !kdata_s2) begin
          state_n   = RECV;
          bit_cnt_n = 4'd1;
        end
      end
      RECV: begin
        if (fall) begin
          to_cnt_n = '0;
          if (bit_cnt == 4'd10) begin
            frame_done = 1'b1;
            state_n    = IDLE;
            bit_cnt_n  = '0;
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout   = 1'b1;
          state_n   = IDLE;
          bit_cnt_n = '0;
          to_cnt_n  = '0;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Data and parity bits shift in from the top; after nine shifts rx_sr = {parity, data[7:0]}.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rx_sr <= '0;
    end else if (state == RECV && fall && bit_cnt != 4'd10) begin
      rx_sr <= {kdata_s2, rx_sr[8:1]};
    end
  end

  assign rx_byte = rx_sr[7:0];

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^rx_sr;
`else
  assign parity_ok = 1'b1;
`endif

  // The stop bit is taken live from the synchroniser on the completing edge.
  assign frame_ok = kdata_s2 & parity_ok;

  always_comb begin
    btns_n = btns;
    for (int unsigned i = 0; i < NB; i++) begin
      if (KEYMAP[i*9 +: 9] == {ext, rx_byte}) btns_n[i] = ~brk;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      btns       <= '0;
      scan_code  <= '0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      ext        <= 1'b0;
      brk        <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (timeout) begin
        frame_err <= 1'b1;
        ext       <= 1'b0;
        brk       <= 1'b0;
      end else if (frame_done) begin
        if (frame_ok) begin
          scan_valid <= 1'b1;
          scan_code  <= rx_byte;
          if (rx_byte == 8'hE0) begin
            ext <= 1'b1;
          end else if (rx_byte == 8'hF0) begin
            brk <= 1'b1;
          end else begin
            btns <= btns_n;
            ext  <= 1'b0;
            brk  <= 1'b0;
          end
        end else begin
          frame_err <= 1'b1;
          ext       <= 1'b0;
          brk       <= 1'b0;
        end
      end
    end
  end

endmodule
